// File: rtl/pattern_entry_checker_if.sv
// pattern_entry_checker_if: pattern/entry inputs and scoring outputs of the pattern entry checker
interface pattern_entry_checker_if;
  logic [20:0] concat;
  logic        pat_valid;
  logic [1:0]  difficulty;
  logic        bit_in;
  logic        bit_stb;
  logic        show_pattern;
  logic        busy;
  logic        result_valid;
  logic        match;
  logic        timeout;
  logic [7:0]  hits;
  logic [7:0]  misses;
  modport master(
    output concat, pat_valid, difficulty, bit_in, bit_stb,
    input  show_pattern, busy, result_valid, match, timeout, hits, misses
  );
  modport slave(
    input  concat, pat_valid, difficulty, bit_in, bit_stb,
    output show_pattern, busy, result_valid, match, timeout, hits, misses
  );
endinterface

// File: rtl/pattern_entry_checker.sv
// pattern_entry_checker: captures a 21-bit segment pattern and scores the player's serial entry against it
module pattern_entry_checker #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  pattern_entry_checker_if.slave p
);
  typedef enum logic [2:0] {IDLE, CAPTURE, ENTRY, COMPARE, RESULT} state_t;
  localparam logic [15:0] T = 16'(TIMEOUT_CYCLES);
  state_t state, state_nx;
  logic [20:0] target, entry;
  logic [1:0] diff_q;
  logic [4:0] bit_cnt;
  logic [15:0] timer, limit;
  logic hidden, match_q, timeout_q, stb_ok, last_bit, expired, same;
  logic [7:0] hits, misses;
  assign limit = diff_q == 2'd0 ? T : diff_q == 2'd1 ? T >> 1 : T >> 2;
  assign stb_ok = state == ENTRY && p.bit_stb;
  assign last_bit = stb_ok && bit_cnt == 5'd20;
  assign expired = state == ENTRY && timer == limit - 16'd1;
  assign same = entry == target;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = p.pat_valid ? CAPTURE : IDLE;
      CAPTURE: state_nx = ENTRY;
      ENTRY:   state_nx = last_bit ? COMPARE : expired ? RESULT : ENTRY;
      COMPARE: state_nx = RESULT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    p.show_pattern = !hidden;
    p.busy = state == CAPTURE || state == ENTRY || state == COMPARE;
    p.result_valid = state == RESULT;
  end
  // the completing strobe outranks an expiring window on the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      target    <= '0;
      entry     <= '0;
      diff_q    <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      hidden    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      hits      <= '0;
      misses    <= '0;
    end else begin
      if (state == CAPTURE) begin
        target  <= p.concat;
        diff_q  <= p.difficulty;
        entry   <= '0;
        bit_cnt <= '0;
        timer   <= '0;
        hidden  <= 1'b0;
      end
      if (state == ENTRY) timer <= timer + 16'd1;
      if (stb_ok) begin
        entry   <= {entry[19:0], p.bit_in};
        bit_cnt <= bit_cnt + 5'd1;
        hidden  <= 1'b1;
      end
      if (state == RESULT) hidden <= 1'b0;
      if (state == COMPARE) begin
        match_q   <= same;
        timeout_q <= 1'b0;
        if (same) hits <= hits + 8'(hits != 8'hFF);
        else misses <= misses + 8'(misses != 8'hFF);
      end
      if (expired && !last_bit) begin
        match_q   <= 1'b0;
        timeout_q <= 1'b1;
        misses    <= misses + 8'(misses != 8'hFF);
      end
    end
  assign p.match = match_q;
  assign p.timeout = timeout_q;
  assign p.hits = hits;
  assign p.misses = misses;
endmodule

// File: tb/tb_pattern_entry_checker.sv
// tb_pattern_entry_checker: two checkers (short and long window) driven in lockstep against an attempt-level model
module tb_pattern_entry_checker;
  localparam int TA = 16, TB = 40, NC = 64;
  localparam logic [20:0] RST_OUT = 21'h100000;
  logic clk = 1'b0, reset = 1'b1;
  logic [20:0] concat;
  logic pat_valid, bit_in, bit_stb, chk_en;
  logic [1:0] difficulty;
  logic [20:0] obs[2], exp_o[2];
  int total = 0, bad = 0;
  int m_hits[2], m_miss[2], rv_c[2];
  logic m_match[2], m_to[2];
  pattern_entry_checker_if ia();
  pattern_entry_checker_if ib();
  assign ia.concat = concat;
  assign ia.pat_valid = pat_valid;
  assign ia.difficulty = difficulty;
  assign ia.bit_in = bit_in;
  assign ia.bit_stb = bit_stb;
  assign ib.concat = concat;
  assign ib.pat_valid = pat_valid;
  assign ib.difficulty = difficulty;
  assign ib.bit_in = bit_in;
  assign ib.bit_stb = bit_stb;
  pattern_entry_checker #(.TIMEOUT_CYCLES(TA)) dut_a (.clk(clk), .reset(reset), .p(ia.slave));
  pattern_entry_checker #(.TIMEOUT_CYCLES(TB)) dut_b (.clk(clk), .reset(reset), .p(ib.slave));
  assign obs[0] = {ia.show_pattern, ia.busy, ia.result_valid, ia.match, ia.timeout, ia.hits, ia.misses};
  assign obs[1] = {ib.show_pattern, ib.busy, ib.result_valid, ib.match, ib.timeout, ib.hits, ib.misses};
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 2; i++) chk($sformatf("outputs_%0d", i), 32'(obs[i]), 32'(exp_o[i]));

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_hits[i] = 0; m_miss[i] = 0; m_match[i] = 1'b0; m_to[i] = 1'b0; exp_o[i] = RST_OUT;
    end
  endtask

  // cycle 0 presents the pattern, cycle 1 is capture, entry window starts at cycle 2
  task automatic attempt(input logic [20:0] pat, input logic [1:0] d, input logic [20:0] ent,
                         input int nsend, input int s, input int dens);
    logic sb[NC];
    logic bb[NC];
    logic [20:0] e;
    logic nmatch[2], nto[2];
    int k, t, lim, cnt, done, ncyc;
    int endc[2], fs[2], nh[2], nm[2];
    k = 0;
    for (int c = 0; c < NC; c++) begin
      sb[c] = c >= s && k < nsend && $urandom_range(99) < dens;
      bb[c] = (sb[c] && k < 21) ? ent[20 - k] : 1'($urandom);
      if (sb[c]) k++;
    end
    ncyc = 0;
    for (int i = 0; i < 2; i++) begin
      t = i == 1 ? TB : TA;
      lim = d == 2'd0 ? t : d == 2'd1 ? t / 2 : t / 4;
      cnt = 0; done = -1; e = '0; fs[i] = -1;
      for (int j = 0; j < lim && done < 0; j++)
        if (sb[2 + j]) begin
          if (fs[i] < 0) fs[i] = j;
          e = {e[19:0], bb[2 + j]};
          cnt++;
          if (cnt == 21) done = j;
        end
      endc[i] = done >= 0 ? done + 4 : lim + 2;
      nto[i] = done < 0;
      nmatch[i] = done >= 0 && e == pat;
      nh[i] = m_hits[i] + int'(nmatch[i] && m_hits[i] < 255);
      nm[i] = m_miss[i] + int'(!nmatch[i] && m_miss[i] < 255);
      if (endc[i] + 2 > ncyc) ncyc = endc[i] + 2;
      rv_c[i] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      pat_valid = c == 0;
      concat = c <= 1 ? pat : 21'($urandom);
      difficulty = c <= 1 ? d : 2'($urandom);
      bit_stb = sb[c];
      bit_in = bb[c];
      for (int i = 0; i < 2; i++) begin
        if (obs[i][18]) rv_c[i] = c;
        exp_o[i] = {c > endc[i] || !(fs[i] >= 0 && fs[i] < c - 2), c >= 1 && c < endc[i], c == endc[i],
                    c >= endc[i] ? nmatch[i] : m_match[i], c >= endc[i] ? nto[i] : m_to[i],
                    8'(c >= endc[i] ? nh[i] : m_hits[i]), 8'(c >= endc[i] ? nm[i] : m_miss[i])};
      end
    end
    for (int i = 0; i < 2; i++) begin
      m_hits[i] = nh[i]; m_miss[i] = nm[i]; m_match[i] = nmatch[i]; m_to[i] = nto[i];
    end
  endtask

  task automatic reset_mid();
    chk_en = 1'b0;
    @(posedge clk); #1;
    pat_valid = 1'b1; concat = 21'h0ABCDE; difficulty = 2'd0; bit_stb = 1'b0;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      bit_stb = 1'b1; bit_in = 1'($urandom);
    end
    #2 reset = 1'b1;
    #1;
    chk("reset_async_a", 32'(obs[0]), 32'(RST_OUT));
    chk("reset_async_b", 32'(obs[1]), 32'(RST_OUT));
    @(posedge clk); #1;
    reset = 1'b0; bit_stb = 1'b0;
    model_clear();
    chk_en = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ra[4], rb[4];
    logic [20:0] p, en;
    ra = '{18, 10, 6, 6};
    rb = '{42, 22, 12, 12};
    concat = '0; pat_valid = 1'b0; difficulty = '0; bit_in = 1'b0; bit_stb = 1'b0;
    model_clear();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state_b", 32'(obs[1]), 32'(RST_OUT));
    attempt(21'h1FBF7E, 2'd0, 21'h1FBF7E, 21, 2, 100);
    chk("match_rv_cycle", rv_c[1], 24);
    chk("match_match", ib.match, 1);
    chk("match_timeout", ib.timeout, 0);
    chk("match_hits", ib.hits, 1);
    chk("short_window_timeout", ia.timeout, 1);
    attempt(21'h1FBF7E, 2'd0, 21'h1FBF7F, 22, 2, 100);
    chk("mismatch_match", ib.match, 0);
    chk("mismatch_misses", ib.misses, 1);
    chk("mismatch_hits", ib.hits, 1);
    for (int d = 0; d < 4; d++) begin
      attempt(21'h1FBF7E, 2'(d), 21'h1FBF7E, 5, 2, 100);
      chk($sformatf("timeout_cycle_a_d%0d", d), rv_c[0], ra[d]);
      chk($sformatf("timeout_cycle_b_d%0d", d), rv_c[1], rb[d]);
      chk($sformatf("timeout_flag_d%0d", d), ia.timeout, 1);
    end
    chk("timeout_misses_b", ib.misses, 5);
    attempt(21'h155AA5, 2'd0, 21'h155AA5, 21, 21, 100);
    chk("boundary_rv_cycle", rv_c[1], 43);
    chk("boundary_match", ib.match, 1);
    chk("boundary_timeout", ib.timeout, 0);
    repeat (40) begin
      p = 21'($urandom);
      case ($urandom_range(2))
        0: en = p;
        1: en = p ^ (21'd1 << $urandom_range(20));
        default: en = 21'($urandom);
      endcase
      attempt(p, 2'($urandom), en, $urandom_range(23, 19), $urandom_range(5), $urandom_range(100, 50));
    end
    reset_mid();
    repeat (257) begin
      p = 21'($urandom);
      attempt(p, 2'd0, p, 21, 2, 100);
    end
    chk("sat_hits", ib.hits, 255);
    chk("sat_hits_misses", ib.misses, 0);
    repeat (257) begin
      p = 21'($urandom);
      attempt(p, 2'd0, p ^ 21'h010000, 21, 2, 100);
    end
    chk("sat_misses", ib.misses, 255);
    chk("sat_misses_hits", ib.hits, 255);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_entry_checker.md
# pattern_entry_checker

Receiving end of the pattern game: captures the 21-bit segment pattern `{display1, display2, display3}` (active-low segments) driven by the pattern generator. It then accepts the player's attempt as a serial bit stream and compares the two. It also keeps running hit/miss tallies and drives the generator's display-enable input (`from_manoj`).

## Interface
- `TIMEOUT_CYCLES`, default 1000: entry window in clock cycles at difficulty 00. Legal range is 4..65535.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `concat` in 21: pattern from the generator, with display1 in bits [20:14], display2 in [13:7] and display3 in [6:0].
- `pat_valid` in 1: the generator asserts this while `concat` holds a stable pattern.
- `difficulty` in 2: difficulty level; sampled at capture.
- `bit_in` in 1: player entry bit, qualified by `bit_stb`.
- `bit_stb` in 1: one-cycle strobe that marks `bit_in` valid.
- `show_pattern` out 1: display enable, connected to the generator's `from_manoj`.
- `busy` out 1: high while in CAPTURE, ENTRY or COMPARE.
- `result_valid` out 1: one-cycle pulse when an attempt finishes.
- `match` out 1: result of the last attempt; held until the next result.
- `timeout` out 1: last attempt expired; held until the next result.
- `hits` out 8: count of matched attempts; saturates at 255.
- `misses` out 8: count of mismatched or timed-out attempts; saturates at 255.

## Operation
- State machine states: IDLE, CAPTURE, ENTRY, COMPARE, RESULT.
- IDLE:
  - `show_pattern`=1.
  - `pat_valid`=1 moves to CAPTURE. Otherwise the machine stays in IDLE.
  - `bit_stb` is ignored.
- CAPTURE (1 cycle):
  - target ← `concat`.
  - diff_q ← `difficulty`.
  - entry ← 0, bit_cnt ← 0, timer ← 0.
  - Next state is ENTRY.
- ENTRY:
  - On `bit_stb`: entry ← {entry[19:0], `bit_in`} and bit_cnt ← bit_cnt+1. The first bit received is the MSB (display1 bit 6).
  - `show_pattern` stays 1 until the first accepted strobe, then goes 0 for the rest of the attempt.
  - timer increments every ENTRY cycle.
  - A strobe that brings bit_cnt to 21 moves to COMPARE.
  - Otherwise, when timer == limit−1, the machine moves to RESULT with a timeout.
  - The window limit is TIMEOUT_CYCLES for diff_q=00, TIMEOUT_CYCLES>>1 for 01, and TIMEOUT_CYCLES>>2 for 10 and 11.
  - Once in ENTRY, `pat_valid` and `concat` are ignored.
- COMPARE (1 cycle):
  - On entry == target: `hits`+1 (saturating) and `match` ← 1.
  - On mismatch: `misses`+1 (saturating) and `match` ← 0.
  - `timeout` ← 0.
  - Next state is RESULT.
- Timeout path:
  - `misses`+1 (saturating), `match` ← 0, `timeout` ← 1.
  - These update on the same edge that enters RESULT.
- RESULT (1 cycle):
  - `result_valid`=1.
  - Next state is IDLE.
- Strobes in CAPTURE, COMPARE, RESULT or IDLE are dropped, so extra bits after the 21st have no effect.
- Simultaneous events: if the 21st strobe lands on the timer == limit−1 cycle, the strobe wins and the attempt is compared.
- Reset:
  - State → IDLE, all registers → 0, `show_pattern`=1.
  - Reset asserted mid-attempt discards the attempt and leaves the counters at 0.

## Timing
- Reset values: `show_pattern`=1, `busy`=0, `result_valid`=0, `match`=0, `timeout`=0, `hits`=0, `misses`=0.
- `pat_valid` sampled at edge N puts the machine in CAPTURE at N, and in ENTRY from edge N+1.
- If the 21st strobe is at edge M, the result registers update at edge M+1 and `result_valid` is high for the cycle after M+1. The machine is back in IDLE at M+2.
- Timeout: ENTRY lasts exactly `limit` cycles with no completing strobe. `result_valid` goes high one cycle after the last ENTRY cycle.
- All outputs are registered or decoded from the state register only, with no input-to-output combinational paths.
- Back-to-back strobes every cycle are supported. The minimum attempt is 1 + 21 + 1 + 1 cycles.

## Test plan
- **Reset:** assert `reset` asynchronously mid-ENTRY.
  - Outputs go to reset values immediately.
  - `show_pattern`=1 and `hits`=`misses`=0.
- **Match:** `concat`=21'h1FBF7E with `pat_valid` pulsed, then the same 21 bits are sent MSB-first on consecutive strobes.
  - `result_valid` pulses.
  - `match`=1, `timeout`=0, `hits`=1.
  - `show_pattern` is 0 from the first strobe until IDLE.
- **Mismatch:** same pattern, but bit 0 is flipped in the entry.
  - `match`=0, `misses`=1, `hits` unchanged.
  - A 22nd strobe sent afterwards is ignored.
- **Timeout per difficulty:** TIMEOUT_CYCLES=16; send 5 bits, then stop.
  - The result pulses after 16, 8, 4 and 4 ENTRY cycles for difficulty 00, 01, 10 and 11 respectively.
  - `timeout`=1 and `misses` increments each time.
- **Boundary:** the 21st strobe lands on the timer == limit−1 cycle with a correct entry.
  - `match`=1, `timeout`=0.
- **Saturation:** run 256 matching attempts, then 1 more.
  - `hits` stays at 255 and `misses`=0.
  - Repeat with mismatches to check that `misses` saturates at 255.
